// File: rtl/result_char_tx.sv
// result_char_tx
// Captures an unsigned binary result, converts it to decimal with an iterative
// double-dabble (one bit per cycle), and streams it out as ASCII characters,
// most significant digit first with leading zeros suppressed, followed by a
// terminator character.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   i_result_vld one-cycle capture pulse, ignored while o_busy is high
//   i_result     unsigned value to print (W bits)
//   o_busy       high while a value is being converted or sent
//   o_vld        o_char holds a character offered to the sink
//   o_char       ASCII character
//   i_stall      sink back-pressure; a character moves when o_vld & !i_stall
//   o_done       one-cycle pulse after the terminator is accepted
module result_char_tx #(
  parameter int         W    = 32,
  parameter int         NDIG = 10,
  parameter logic [7:0] TERM = 8'h0A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_result_vld,
  input  logic [W-1:0] i_result,
  output logic         o_busy,
  output logic         o_vld,
  output logic [7:0]   o_char,
  input  logic         i_stall,
  output logic         o_done
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(W + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] IDX_TOP  = IW'(NDIG - 1);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CONV = 3'd1,
    ST_SKIP = 3'd2,
    ST_EMIT = 3'd3,
    ST_TERM = 3'd4
  } state_t;

  // Adds 3 to every BCD digit that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [BW-1:0] dd_adjust(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic [3:0]    d;
    r = b;
    for (int k = 0; k < NDIG; k++) begin
      d = b[4*k +: 4];
      if (d >= 4'd5) begin
        r[4*k +: 4] = d + 4'd3;
      end else begin
        r[4*k +: 4] = d;
      end
    end
    return r;
  endfunction

  // Selects one BCD digit by index as an explicit mux.
  function automatic logic [3:0] digit_at(input logic [BW-1:0] b, input logic [IW-1:0] i);
    logic [3:0] d;
    d = 4'd0;
    for (int k = 0; k < NDIG; k++) begin
      if (IW'(k) == i) begin
        d = b[4*k +: 4];
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

  state_t        state_r, state_s;
  logic [W-1:0]  bin_r, bin_s;
  logic [BW-1:0] bcd_r, bcd_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [IW-1:0] idx_r, idx_s;

  logic          vld_r, vld_s;
  logic [7:0]    char_r, char_s;
  logic          done_r, done_s;
  logic          busy_r, busy_s;

  logic [BW-1:0] adj_s;
  logic [BW-1:0] shift_bcd_s;
  logic [W-1:0]  shift_bin_s;

  // One double-dabble step: correct digits, then shift {bcd, bin} left by one.
  assign adj_s       = dd_adjust(bcd_r);
  assign shift_bcd_s = {adj_s[BW-2:0], bin_r[W-1]};
  assign shift_bin_s = {bin_r[W-2:0], 1'b0};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      bin_r   <= {W{1'b0}};
      bcd_r   <= {BW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      idx_r   <= IDX_ZERO;
    end else begin
      state_r <= state_s;
      bin_r   <= bin_s;
      bcd_r   <= bcd_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_s = state_r;
    bin_s   = bin_r;
    bcd_s   = bcd_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (i_result_vld) begin
          bin_s   = i_result;
          bcd_s   = {BW{1'b0}};
          cnt_s   = CW'(W);
          idx_s   = IDX_ZERO;
          state_s = ST_CONV;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CONV: begin
        bin_s = shift_bin_s;
        bcd_s = shift_bcd_s;
        cnt_s = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          // Look at the finished top digit now so that SKIP lasts exactly
          // one cycle per suppressed leading zero.
          idx_s = IDX_TOP;
          if ((digit_at(shift_bcd_s, IDX_TOP) == 4'd0) && (IDX_TOP != IDX_ZERO)) begin
            state_s = ST_SKIP;
          end else begin
            state_s = ST_EMIT;
          end
        end else begin
          state_s = ST_CONV;
        end
      end
      ST_SKIP: begin
        // Entered only when digit[idx] is zero and idx > 0; move down one
        // digit and leave as soon as the new digit is printable.
        idx_s = idx_r - IDX_ONE;
        if ((digit_at(bcd_r, idx_r - IDX_ONE) != 4'd0) || (idx_r == IDX_ONE)) begin
          state_s = ST_EMIT;
        end else begin
          state_s = ST_SKIP;
        end
      end
      ST_EMIT: begin
        if (!i_stall) begin
          if (idx_r != IDX_ZERO) begin
            idx_s   = idx_r - IDX_ONE;
            state_s = ST_EMIT;
          end else begin
            state_s = ST_TERM;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_TERM: begin
        if (!i_stall) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_TERM;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the state they describe.
  always_comb begin
    vld_s  = (state_s == ST_EMIT) || (state_s == ST_TERM);
    busy_s = (state_s != ST_IDLE);
    done_s = (state_r == ST_TERM) && !i_stall;
    case (state_s)
      ST_EMIT: begin
        char_s = 8'h30 + {4'd0, digit_at(bcd_s, idx_s)};
      end
      ST_TERM: begin
        char_s = TERM;
      end
      default: begin
        char_s = 8'h00;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r  <= 1'b0;
      char_r <= 8'h00;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      vld_r  <= vld_s;
      char_r <= char_s;
      done_r <= done_s;
      busy_r <= busy_s;
    end
  end

  assign o_vld  = vld_r;
  assign o_char = char_r;
  assign o_done = done_r;
  assign o_busy = busy_r;

endmodule

// File: doc/result_char_tx.md
# result_char_tx

Serialises a binary result into decimal ASCII text: the value is captured on a valid pulse, converted to decimal, and sent one character at a time followed by a terminator. It uses the same valid/stall character protocol as the puzzle solver's input stream, but in the other direction. It sits downstream of the solver's result port and feeds a UART or log sink. Conversion is iterative double-dabble, one bit per cycle, with no dividers.

## Interface
- W, 32, result width in bits.
- NDIG, 10, BCD digit count; must satisfy 10^NDIG > 2^W - 1.
- TERM, 8'h0A, terminator character sent after the last digit.

- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (low = reset).
- i_result_vld  input  1  one-cycle pulse; i_result is valid.
- i_result  input  W  unsigned value to print.
- o_busy  output  1  high while a value is being converted or sent.
- o_vld  output  1  o_char is valid.
- o_char  output  8  ASCII character.
- i_stall  input  1  sink back-pressure.
- o_done  output  1  one-cycle pulse when the terminator is accepted.

## Operation
- States: IDLE, CONV, SKIP, EMIT, TERM.
- IDLE: if i_result_vld, capture i_result into bin[W-1:0], clear bcd[4*NDIG-1:0], load bit counter = W, and go to CONV.
  - i_result_vld is ignored while o_busy = 1. There is no queue and no error flag.
- CONV: one step per cycle.
  - Every BCD digit >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - Counter decrements; after W steps, set idx = NDIG-1 and go to SKIP.
- SKIP: suppresses leading zeros.
  - If digit[idx] == 0 and idx > 0: decrement idx, stay in SKIP, emit nothing.
  - Otherwise go to EMIT.
  - Value 0 therefore prints a single "0".
- EMIT: o_vld = 1, o_char = 8'h30 + digit[idx].
  - On an edge with i_stall = 0, the character is accepted.
  - If idx > 0, decrement idx; otherwise go to TERM.
- TERM: o_vld = 1, o_char = TERM; on acceptance go to IDLE and pulse o_done.
- Acceptance rule: a character transfers on a rising edge where o_vld = 1 and i_stall = 0.
  - While stalled, o_vld and o_char hold stable.
  - Each character is sent exactly once.
- o_busy = (state != IDLE).
- Arithmetic:
  - Digits are 4-bit; the +3 correction is applied only when the digit is >= 5, so no digit exceeds 9 after the shift.
  - The top digit cannot overflow when the NDIG constraint holds.
  - The bit counter is sized $clog2(W+1).

## Timing
- Reset (rst low, asynchronous) forces:
  - state = IDLE; o_vld = 0, o_char = 8'h00, o_busy = 0, o_done = 0.
  - bin, bcd and idx cleared.
  - This applies at any point mid-operation. No partial output resumes; a result arriving during reset is lost.
- Let the capture edge be E0 (i_result_vld high, state IDLE).
  - o_busy = 1 from after E0.
  - The W conversion steps occur on edges E1..EW.
  - SKIP lasts z cycles, where z = number of leading zero digits, capped at NDIG-1.
  - o_vld first reads 1 in the cycle after edge E(W+z).
- With no stall, one character is sent per cycle: n digits plus TERM take n+1 consecutive cycles.
- o_done is registered. It is high for exactly the one cycle after the TERM-accept edge, and o_busy is 0 in that same cycle.
  - An i_result_vld in that cycle is captured, giving a back-to-back gap of 0 idle cycles.
- i_stall is ignored when o_vld = 0.
- i_stall held high indefinitely holds the current character with no timeout.

## Test plan
- i_result = 123, i_stall = 0 → o_char sequence 0x31, 0x32, 0x33, 0x0A on consecutive cycles.
  - First o_vld appears in the cycle after E39 (W=32, z=7).
  - o_done pulses once, one cycle after 0x0A is accepted.
- i_result = 0 → exactly 0x30 then 0x0A; SKIP lasts 9 cycles.
- i_result = 32'hFFFFFFFF → "4294967295" followed by 0x0A, 11 characters.
  - z = 0, so first o_vld appears in the cycle after E32.
- i_result = 1000000 with i_stall high for 3 cycles on every character → output "1000000" followed by 0x0A.
  - o_char stays stable during every stall; there are no duplicates or drops.
- Second i_result_vld (value 7) pulsed during CONV → ignored, and only the first value prints.
  - A value 5 pulsed in the o_done cycle → accepted immediately, and "5" followed by 0x0A follows.
- Reset after two characters of 98765 are accepted:
  - o_vld, o_busy and o_done read 0 immediately, even before a clock edge.
  - After release, value 42 prints cleanly as 0x34, 0x32, 0x0A.
